// File: rtl/ucie_ctl_phy_sb_cfg_bridge.sv
// Sideband config bridge between the RDI config channel and the PHY sideband.
// TX: show-ahead FIFO to the sideband serialiser, with credit return to the Adapter.
// RX: FIFO from the sideband, drained into the Adapter under PL credit control.
module ucie_ctl_phy_sb_cfg_bridge #(
    parameter int NC       = 32,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4,
    parameter int PL_CRD   = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NC-1:0]                 i_rdi_lp_cfg,
    input  logic                          i_rdi_lp_cfg_valid,
    output logic                          o_rdi_pl_cfg_crd,
    output logic [NC-1:0]                 o_data_sent_sb,
    output logic                          o_sb_data_valid,
    input  logic                          i_sb_tx_ready,
    input  logic [NC-1:0]                 i_data_received_sb,
    input  logic                          i_sb_data_valid,
    output logic [NC-1:0]                 o_rdi_pl_cfg,
    output logic                          o_rdi_pl_cfg_vld,
    input  logic                          i_rdi_lp_cfg_crd,
    output logic [$clog2(PL_CRD+1)-1:0]   o_pl_crd_cnt,
    output logic [2:0]                    o_err,
    input  logic                          i_err_clr
);

    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int CW  = $clog2(PL_CRD+1);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    logic [NC-1:0] tx_mem [TX_DEPTH];
    logic [TAW:0]  tx_wptr, tx_rptr;
    logic          tx_empty, tx_full, tx_push, tx_pop, tx_ovf;

    logic [NC-1:0] rx_mem [RX_DEPTH];
    logic [RAW:0]  rx_wptr, rx_rptr;
    logic          rx_empty, rx_full, rx_push, rx_pop, rx_ovf;

    logic          crd_ovf;
    logic [NC-1:0] pl_cfg_d;
    state_t        state_q, state_d;

    // TX FIFO status and handshake; a full FIFO still accepts when it pops the same cycle
    assign tx_empty = (tx_wptr == tx_rptr);
    assign tx_full  = (tx_wptr == {~tx_rptr[TAW], tx_rptr[TAW-1:0]});
    assign tx_pop   = !tx_empty && i_sb_tx_ready;
    assign tx_push  = i_rdi_lp_cfg_valid && (!tx_full || tx_pop);
    assign tx_ovf   = i_rdi_lp_cfg_valid && !tx_push;

    assign o_sb_data_valid = !tx_empty;
    assign o_data_sent_sb  = tx_empty ? '0 : tx_mem[tx_rptr[TAW-1:0]];

    // RX FIFO status; no backpressure toward the sideband, so overflow drops the beat
    assign rx_empty = (rx_wptr == rx_rptr);
    assign rx_full  = (rx_wptr == {~rx_rptr[RAW], rx_rptr[RAW-1:0]});
    assign rx_push  = i_sb_data_valid && (!rx_full || rx_pop);
    assign rx_ovf   = i_sb_data_valid && !rx_push;

    // Credit return while already at the advertised maximum is an Adapter protocol error
    assign crd_ovf  = i_rdi_lp_cfg_crd && !rx_pop && (o_pl_crd_cnt == CW'(PL_CRD));

    assign o_rdi_pl_cfg_vld = (state_q == SEND);

    // FIFO storage writes
    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem[tx_wptr[TAW-1:0]] <= i_rdi_lp_cfg;
        if (rx_push) rx_mem[rx_wptr[RAW-1:0]] <= i_data_received_sb;
    end

    // FIFO pointers and the one-cycle credit pulse per drained TX entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_wptr          <= '0;
            tx_rptr          <= '0;
            rx_wptr          <= '0;
            rx_rptr          <= '0;
            o_rdi_pl_cfg_crd <= 1'b0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + {{TAW{1'b0}}, 1'b1};
            if (tx_pop)  tx_rptr <= tx_rptr + {{TAW{1'b0}}, 1'b1};
            if (rx_push) rx_wptr <= rx_wptr + {{RAW{1'b0}}, 1'b1};
            if (rx_pop)  rx_rptr <= rx_rptr + {{RAW{1'b0}}, 1'b1};
            o_rdi_pl_cfg_crd <= tx_pop;
        end
    end

    // PL credit counter: pop consumes, return restores, both together cancel
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pl_crd_cnt <= CW'(PL_CRD);
        end else if (rx_pop && !i_rdi_lp_cfg_crd) begin
            o_pl_crd_cnt <= o_pl_crd_cnt - CW'(1);
        end else if (i_rdi_lp_cfg_crd && !rx_pop && !crd_ovf) begin
            o_pl_crd_cnt <= o_pl_crd_cnt + CW'(1);
        end
    end

    // Sticky error flags; a fresh error outranks a same-cycle clear
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_err <= '0;
        end else begin
            o_err <= (i_err_clr ? 3'b000 : o_err) | {crd_ovf, rx_ovf, tx_ovf};
        end
    end

    // Output FSM state register, holding the message presented to the Adapter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            o_rdi_pl_cfg <= '0;
        end else begin
            state_q      <= state_d;
            o_rdi_pl_cfg <= pl_cfg_d;
        end
    end

    // Next state: SEND whenever a message is drained this cycle, from either state
    always_comb begin
        state_d = IDLE;
        if (rx_pop) state_d = SEND;
    end

    // Drain decision and next Adapter message
    always_comb begin
        rx_pop   = !rx_empty && (o_pl_crd_cnt != '0);
        pl_cfg_d = '0;
        if (rx_pop) pl_cfg_d = rx_mem[rx_rptr[RAW-1:0]];
    end

endmodule

// File: tb/tb_ucie_ctl_phy_sb_cfg_bridge.sv
// Scoreboard bench for ucie_ctl_phy_sb_cfg_bridge: a queue-based reference model
// predicts each edge, a monitor on the falling edge checks what the DUT presents.
module tb_ucie_ctl_phy_sb_cfg_bridge;

    localparam int NC  = 32;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int PLC = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NC-1:0] lp_cfg;
    logic          lp_valid;
    logic          pl_crd;
    logic [NC-1:0] sb_tx_data;
    logic          sb_tx_valid;
    logic          ready;
    logic [NC-1:0] rx_data;
    logic          sb_rx_valid;
    logic [NC-1:0] pl_cfg;
    logic          pl_vld;
    logic          lp_crd;
    logic [2:0]    crd_cnt;
    logic [2:0]    err;
    logic          err_clr;

    ucie_ctl_phy_sb_cfg_bridge #(
        .NC(NC), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .PL_CRD(PLC)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_rdi_lp_cfg(lp_cfg),
        .i_rdi_lp_cfg_valid(lp_valid),
        .o_rdi_pl_cfg_crd(pl_crd),
        .o_data_sent_sb(sb_tx_data),
        .o_sb_data_valid(sb_tx_valid),
        .i_sb_tx_ready(ready),
        .i_data_received_sb(rx_data),
        .i_sb_data_valid(sb_rx_valid),
        .o_rdi_pl_cfg(pl_cfg),
        .o_rdi_pl_cfg_vld(pl_vld),
        .i_rdi_lp_cfg_crd(lp_crd),
        .o_pl_crd_cnt(crd_cnt),
        .o_err(err),
        .i_err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [NC-1:0] m_tx[$];
    logic [NC-1:0] m_rx[$];
    logic [NC-1:0] exp_tx[$];
    logic [NC-1:0] exp_rx[$];
    int            m_crd = PLC;
    logic [2:0]    m_err = 3'b000;
    bit            m_crd_pulse = 1'b0;
    bit            m_pl_vld = 1'b0;
    bit            tpop, tpush, rpop, rpush;
    logic [2:0]    new_err;
    logic [NC-1:0] tmp;

    // Model: evaluate what the edge did, using the inputs that were stable across it
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            m_tx.delete(); m_rx.delete(); exp_tx.delete(); exp_rx.delete();
            m_crd = PLC; m_err = 3'b000; m_crd_pulse = 1'b0; m_pl_vld = 1'b0;
        end else begin
            tpop  = (m_tx.size() > 0) && ready;
            tpush = lp_valid && ((m_tx.size() < TXD) || tpop);
            rpop  = (m_rx.size() > 0) && (m_crd > 0);
            rpush = sb_rx_valid && ((m_rx.size() < RXD) || rpop);
            new_err[0] = lp_valid && !tpush;
            new_err[1] = sb_rx_valid && !rpush;
            new_err[2] = lp_crd && !rpop && (m_crd == PLC);
            if (rpop && !lp_crd) m_crd = m_crd - 1;
            else if (lp_crd && !rpop && m_crd < PLC) m_crd = m_crd + 1;
            m_err = (err_clr ? 3'b000 : m_err) | new_err;
            if (tpop) void'(m_tx.pop_front());
            if (tpush) begin m_tx.push_back(lp_cfg); exp_tx.push_back(lp_cfg); end
            m_crd_pulse = tpop;
            m_pl_vld    = rpop;
            if (rpop) begin tmp = m_rx.pop_front(); exp_rx.push_back(tmp); end
            if (rpush) m_rx.push_back(rx_data);
        end
    end

    // Monitor: compare what the DUT presents against the scoreboard between edges
    always @(negedge clk) begin
        if (rst_n) begin
            check("tx_valid", 64'(sb_tx_valid), 64'(m_tx.size() > 0));
            if (sb_tx_valid) begin
                if (exp_tx.size() == 0) check("tx_unexpected", 64'(sb_tx_valid), 64'(0));
                else begin
                    check("tx_head", 64'(sb_tx_data), 64'(exp_tx[0]));
                    if (ready) void'(exp_tx.pop_front());
                end
            end else begin
                check("tx_idle_data", 64'(sb_tx_data), 64'(0));
            end
            check("crd_pulse", 64'(pl_crd), 64'(m_crd_pulse));
            check("pl_vld", 64'(pl_vld), 64'(m_pl_vld));
            if (pl_vld) begin
                if (exp_rx.size() == 0) check("pl_unexpected", 64'(pl_vld), 64'(0));
                else check("pl_data", 64'(pl_cfg), 64'(exp_rx.pop_front()));
            end else begin
                check("pl_idle_data", 64'(pl_cfg), 64'(0));
            end
            check("crd_cnt", 64'(crd_cnt), 64'(m_crd));
            check("err", 64'(err), 64'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic drive(input logic lv, input logic [NC-1:0] ld, input logic sv,
                         input logic [NC-1:0] sd, input logic cr, input logic cl);
        lp_valid = lv; lp_cfg = ld; sb_rx_valid = sv; rx_data = sd; lp_crd = cr; err_clr = cl;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sb_valid"}, 64'(sb_tx_valid), 64'(0));
        check({tag, "_sb_data"},  64'(sb_tx_data),  64'(0));
        check({tag, "_pl_vld"},   64'(pl_vld),      64'(0));
        check({tag, "_pl_cfg"},   64'(pl_cfg),      64'(0));
        check({tag, "_crd"},      64'(pl_crd),      64'(0));
        check({tag, "_cnt"},      64'(crd_cnt),     64'(PLC));
        check({tag, "_err"},      64'(err),         64'(0));
    endtask

    initial begin
        rst_n = 1'b1; ready = 1'b0;
        lp_valid = 1'b0; lp_cfg = '0; sb_rx_valid = 1'b0; rx_data = '0; lp_crd = 1'b0; err_clr = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        step(); step();
        rst_n = 1'b1;
        idle(2);

        // Back-to-back TX with the sideband always ready
        ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, NC'(32'hA0 + i), 1'b0, '0, 1'b0, 1'b0);
        idle(4);

        // TX backpressure: fifth write overflows
        ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, NC'(32'hB0 + i), 1'b0, '0, 1'b0, 1'b0);
        check("bp_err", 64'(err), 64'(3'b001));
        idle(3);
        ready = 1'b1;
        idle(6);
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("bp_err_clr", 64'(err), 64'(0));

        // RX with credits available
        drive(1'b0, '0, 1'b1, 32'h11, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'h22, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'h33, 1'b0, 1'b0);
        idle(3);
        check("rx_cnt_after3", 64'(crd_cnt), 64'(1));
        for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Credit starvation: two beats held until credits return
        for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, NC'(32'hC0 + i), 1'b0, 1'b0);
        idle(6);
        check("starve_cnt", 64'(crd_cnt), 64'(0));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(3);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(3);
        check("starve_err", 64'(err), 64'(0));
        for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(2);

        // Simultaneous return and pop at cnt=2, then overflow return at max
        drive(1'b0, '0, 1'b1, 32'hD0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 32'hD1, 1'b0, 1'b0);
        idle(3);
        drive(1'b0, '0, 1'b1, 32'hD2, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(2);
        check("simul_cnt", 64'(crd_cnt), 64'(2));
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        check("crd_ovf_cnt", 64'(crd_cnt), 64'(PLC));
        check("crd_ovf_err", 64'(err), 64'(3'b100));
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
        check("crd_ovf_clr", 64'(err), 64'(0));

        // Mid-traffic reset with both FIFOs holding entries
        ready = 1'b0;
        for (int i = 0; i < 6; i++)
            drive(i < 2, NC'(32'hE0 + i), 1'b1, NC'(32'hF0 + i), 1'b0, 1'b0);
        idle(3);
        rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        step(); step();
        rst_n = 1'b1;
        ready = 1'b1;
        idle(4);
        check("post_rst_sb_valid", 64'(sb_tx_valid), 64'(0));
        check("post_rst_pl_vld", 64'(pl_vld), 64'(0));

        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 1)), NC'($urandom), 1'($urandom_range(0, 1)), NC'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        end

        // Drain everything
        ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        idle(8);
        check("tx_drained", 64'(exp_tx.size()), 64'(0));
        check("rx_drained", 64'(exp_rx.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
